mem_access_stage: RTL and testbench

- MEM pipeline stage. Sits between the EX/MEM and MEM/WB pipeline registers.
- Consumes the execute-stage results: dest reg, write enable, write data (store data), memory address, load flag and memory aluop.
- Performs LB/LH/LW/LBU/LHU/SB/SH/SW over a byte-wide synchronous RAM port, sequencing one byte per cycle.
- Requests a pipeline stall while a multi-cycle access is in flight.
- Non-memory instructions pass through in zero cycles.

---
 rtl/mem_access_stage_pkg.sv | 47 ++++
 rtl/mem_load_ext.sv | 23 ++
 rtl/mem_access_stage.sv | 175 +++++++++++++++++
 tb/tb_mem_access_stage.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared widths, EX/MEM aluop codes, byte counts and MEM-stage state encodings.
package mem_access_stage_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_W      = 32;
  localparam int unsigned MEM_ADDR_W = 32;
  localparam int unsigned ALUOP_W    = 8;
  localparam int unsigned LO_W       = 24;

  localparam logic [ALUOP_W-1:0] EX_NOP = 8'h00;
  localparam logic [ALUOP_W-1:0] EX_LB  = 8'h20;
  localparam logic [ALUOP_W-1:0] EX_LH  = 8'h21;
  localparam logic [ALUOP_W-1:0] EX_LW  = 8'h22;
  localparam logic [ALUOP_W-1:0] EX_LBU = 8'h23;
  localparam logic [ALUOP_W-1:0] EX_LHU = 8'h24;
  localparam logic [ALUOP_W-1:0] EX_SB  = 8'h25;
  localparam logic [ALUOP_W-1:0] EX_SH  = 8'h26;
  localparam logic [ALUOP_W-1:0] EX_SW  = 8'h27;

  localparam logic [2:0] BYTES_NONE = 3'd0;
  localparam logic [2:0] BYTES_B    = 3'd1;
  localparam logic [2:0] BYTES_H    = 3'd2;
  localparam logic [2:0] BYTES_W    = 3'd4;

  typedef enum logic [0:0] {
    MEM_IDLE = 1'b0,
    MEM_BUSY = 1'b1
  } mem_state_e;

  // Access size in bytes; zero marks a non-memory op.
  function automatic logic [2:0] op_bytes(input logic [ALUOP_W-1:0] op);
    case (op)
      EX_LB, EX_LBU, EX_SB: op_bytes = BYTES_B;
      EX_LH, EX_LHU, EX_SH: op_bytes = BYTES_H;
      EX_LW, EX_SW:         op_bytes = BYTES_W;
      default:              op_bytes = BYTES_NONE;
    endcase
  endfunction

  function automatic logic op_is_load(input logic [ALUOP_W-1:0] op);
    case (op)
      EX_LB, EX_LH, EX_LW, EX_LBU, EX_LHU: op_is_load = 1'b1;
      default:                             op_is_load = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Assembles the buffered low bytes with the final RAM byte and sign/zero-extends per load type.
module mem_load_ext
  import mem_access_stage_pkg::*;
(
  input  logic [ALUOP_W-1:0] i_aluop,
  input  logic [LO_W-1:0]    i_lo_bytes,
  input  logic [7:0]         i_top,
  output logic [REG_W-1:0]   o_data
);

  always_comb begin
    o_data = '0;
    case (i_aluop)
      EX_LB:   o_data = {{24{i_top[7]}}, i_top};
      EX_LBU:  o_data = {24'b0, i_top};
      EX_LH:   o_data = {{16{i_top[7]}}, i_top, i_lo_bytes[7:0]};
      EX_LHU:  o_data = {16'b0, i_top, i_lo_bytes[7:0]};
      EX_LW:   o_data = {i_top, i_lo_bytes};
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: byte-serial loads/stores over a shared RAM port with stall generation.
// Optional alignment trap enabled by defining MEM_ALIGN_CHECK_EN.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned ADDR_W = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [REG_W-1:0]      wdata_i,
  input  logic [MEM_ADDR_W-1:0] mem_addr_i,
  input  logic                  is_ld_i,
  input  logic [ALUOP_W-1:0]    aluop_i,
  input  logic                  mem_gnt_i,
  input  logic [7:0]            mem_din_i,
  output logic                  mem_req_o,
  output logic [ADDR_W-1:0]     mem_a_o,
  output logic [7:0]            mem_dout_o,
  output logic                  mem_wr_o,
  output logic                  stall_req_o,
`ifdef MEM_ALIGN_CHECK_EN
  output logic                  misalign_o,
`endif
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [REG_W-1:0]      wdata_o
);

  mem_state_e       r_state, w_state_nxt;
  logic [2:0]       r_cnt, w_cnt_nxt;
  logic [LO_W-1:0]  r_lo, w_lo_nxt;

  logic [2:0]       w_n;
  logic             w_is_mem;
  logic             w_is_load;
  logic             w_misalign;
  logic             w_mem_ok;
  logic             w_go;
  logic [2:0]       w_k;
  logic [2:0]       w_last;
  logic             w_done;
  logic             w_issue;
  logic [7:0]       w_st_byte;
  logic [REG_W-1:0] w_ld_data;
  logic             w_unused_addr;

  assign w_n       = op_bytes(aluop_i);
  assign w_is_mem  = (w_n != BYTES_NONE);
  assign w_is_load = op_is_load(aluop_i);

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = w_is_mem &
                      (((w_n == BYTES_H) & mem_addr_i[0]) |
                       ((w_n == BYTES_W) & (mem_addr_i[1:0] != 2'b00)));
`else
  assign w_misalign = 1'b0;
`endif

  // Byte index k: 0 on the first granted cycle, then the running count.
  assign w_mem_ok = w_is_mem & ~w_misalign;
  assign w_go     = w_mem_ok & ((r_state == MEM_BUSY) | mem_gnt_i);
  assign w_k      = (r_state == MEM_BUSY) ? r_cnt : 3'd0;
  assign w_last   = w_is_load ? w_n : (w_n - 3'd1);
  assign w_done   = w_go & (w_k == w_last);
  assign w_issue  = w_go & (w_k < w_n);

  assign w_unused_addr = ^mem_addr_i[MEM_ADDR_W-1:ADDR_W];

  always_comb begin
    case (w_k[1:0])
      2'd0:    w_st_byte = wdata_i[7:0];
      2'd1:    w_st_byte = wdata_i[15:8];
      2'd2:    w_st_byte = wdata_i[23:16];
      default: w_st_byte = wdata_i[31:24];
    endcase
  end

  mem_load_ext u_load_ext (
    .i_aluop    (aluop_i),
    .i_lo_bytes (r_lo),
    .i_top      (mem_din_i),
    .o_data     (w_ld_data)
  );

  // State register, byte counter and load buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= MEM_IDLE;
      r_cnt   <= 3'd0;
      r_lo    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_lo    <= w_lo_nxt;
    end
  end

  // Next state; load bytes 0..N-2 are captured as they return in cycles 1..N-1.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_lo_nxt    = r_lo;
    case (r_state)
      MEM_IDLE: begin
        if (w_go && !w_done) begin
          w_state_nxt = MEM_BUSY;
          w_cnt_nxt   = 3'd1;
        end
      end
      MEM_BUSY: begin
        if (w_done || !w_mem_ok) begin
          w_state_nxt = MEM_IDLE;
          w_cnt_nxt   = 3'd0;
        end else begin
          w_cnt_nxt = r_cnt + 3'd1;
          if (w_is_load) begin
            case (r_cnt)
              3'd1:    w_lo_nxt[7:0]   = mem_din_i;
              3'd2:    w_lo_nxt[15:8]  = mem_din_i;
              3'd3:    w_lo_nxt[23:16] = mem_din_i;
              default: w_lo_nxt        = r_lo;
            endcase
          end
        end
      end
      default: begin
        w_state_nxt = MEM_IDLE;
        w_cnt_nxt   = 3'd0;
      end
    endcase
  end

  // Outputs; write-back fields stay zero until the done cycle of a memory op.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_a_o     = '0;
    mem_dout_o  = 8'h00;
    mem_wr_o    = 1'b0;
    stall_req_o = 1'b0;
    wd_o        = '0;
    wreg_o      = 1'b0;
    wdata_o     = '0;
`ifdef MEM_ALIGN_CHECK_EN
    misalign_o  = 1'b0;
`endif
    if (!rst) begin
      wd_o = wd_i;
      if (!w_is_mem) begin
        wreg_o  = wreg_i & ~(is_ld_i & (aluop_i != EX_NOP));
        wdata_o = wdata_i;
      end else if (w_misalign) begin
`ifdef MEM_ALIGN_CHECK_EN
        misalign_o = 1'b1;
`endif
      end else begin
        mem_req_o   = 1'b1;
        stall_req_o = ~w_done;
        if (w_issue) begin
          mem_a_o = mem_addr_i[ADDR_W-1:0] + ADDR_W'(w_k);
          if (!w_is_load) begin
            mem_wr_o   = 1'b1;
            mem_dout_o = w_st_byte;
          end
        end
        if (w_done && w_is_load) begin
          wreg_o  = wreg_i;
          wdata_o = w_ld_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: byte RAM model, grant control, per-op write-back checks.
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  localparam int unsigned ADDR_W = 17;
  localparam int unsigned RAM_SZ = 1 << ADDR_W;
  localparam int          MAX_CYC = 40;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [REG_ADDR_W-1:0] wd_i;
  logic                  wreg_i;
  logic [REG_W-1:0]      wdata_i;
  logic [MEM_ADDR_W-1:0] mem_addr_i;
  logic                  is_ld_i;
  logic [ALUOP_W-1:0]    aluop_i;
  logic                  mem_gnt_i;
  logic [7:0]            mem_din_i;
  logic                  mem_req_o;
  logic [ADDR_W-1:0]     mem_a_o;
  logic [7:0]            mem_dout_o;
  logic                  mem_wr_o;
  logic                  stall_req_o;
  logic [REG_ADDR_W-1:0] wd_o;
  logic                  wreg_o;
  logic [REG_W-1:0]      wdata_o;
`ifdef MEM_ALIGN_CHECK_EN
  logic                  misalign;
`endif

  logic [7:0]        ram [0:RAM_SZ-1];
  logic              bd_we;
  logic [ADDR_W-1:0] bd_a;
  logic [7:0]        bd_d;

  typedef struct {
    logic [REG_ADDR_W-1:0] wd;
    logic                  wreg;
    logic [REG_W-1:0]      wdata;
    bit                    chk_data;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .wd_i        (wd_i),
    .wreg_i      (wreg_i),
    .wdata_i     (wdata_i),
    .mem_addr_i  (mem_addr_i),
    .is_ld_i     (is_ld_i),
    .aluop_i     (aluop_i),
    .mem_gnt_i   (mem_gnt_i),
    .mem_din_i   (mem_din_i),
    .mem_req_o   (mem_req_o),
    .mem_a_o     (mem_a_o),
    .mem_dout_o  (mem_dout_o),
    .mem_wr_o    (mem_wr_o),
    .stall_req_o (stall_req_o),
`ifdef MEM_ALIGN_CHECK_EN
    .misalign_o  (misalign),
`endif
    .wd_o        (wd_o),
    .wreg_o      (wreg_o),
    .wdata_o     (wdata_o)
  );

  // Synchronous byte RAM with a backdoor preload port.
  always @(posedge clk) begin
    if (bd_we) ram[bd_a] <= bd_d;
    else if (mem_wr_o) ram[mem_a_o] <= mem_dout_o;
    mem_din_i <= ram[mem_a_o];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [ALUOP_W-1:0] op);
    case (op)
      EX_LB, EX_LBU, EX_SB: return 1;
      EX_LH, EX_LHU, EX_SH: return 2;
      EX_LW, EX_SW:         return 4;
      default:              return 0;
    endcase
  endfunction

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    bd_we = 1'b1; bd_a = a; bd_d = d;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  task automatic run_op(input logic [ALUOP_W-1:0] op, input logic ld, input logic [31:0] addr,
                        input logic [31:0] data, input logic [4:0] wd, input logic wreg,
                        input int gnt_delay, input logic exp_wreg, input logic [31:0] exp_data,
                        input int exp_stall);
    exp_t e;
    int   n, cyc, stalls, j, wr_k;
    bit   done, is_mem, is_store;
    n        = nbytes(op);
    is_mem   = (n != 0);
    is_store = (op == EX_SB) || (op == EX_SH) || (op == EX_SW);
    e.wd = wd; e.wreg = exp_wreg; e.wdata = exp_data; e.chk_data = !is_store;
    sb_q.push_back(e);
    aluop_i = op; is_ld_i = ld; mem_addr_i = addr; wdata_i = data; wd_i = wd; wreg_i = wreg;
    mem_gnt_i = (gnt_delay == 0);
    cyc = 0; stalls = 0; j = 0; wr_k = 0; done = 1'b0;
    while (!done && cyc < MAX_CYC) begin
      @(negedge clk);
      check("req", 32'(mem_req_o), 32'(is_mem));
      if (!mem_gnt_i) check("wait_wr", 32'(mem_wr_o), 32'd0);
      else if (is_mem && !is_store && j < n) begin
        check("ld_addr", 32'(mem_a_o), (addr + 32'(j)) & 32'h1FFFF);
        j++;
      end
      if (mem_wr_o) begin
        check("st_addr", 32'(mem_a_o), (addr + 32'(wr_k)) & 32'h1FFFF);
        check("st_dout", 32'(mem_dout_o), (data >> (8 * wr_k)) & 32'hFF);
        wr_k++;
      end
      if (stall_req_o) begin
        stalls++;
        check("partial_wreg", 32'(wreg_o), 32'd0);
        check("partial_wdata", wdata_o, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("wd", 32'(wd_o), 32'(e.wd));
        check("wreg", 32'(wreg_o), 32'(e.wreg));
        if (e.chk_data) check("wdata", wdata_o, e.wdata);
        done = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
      if (cyc >= gnt_delay) mem_gnt_i = 1'b1;
    end
    check("done", 32'(done), 32'd1);
    if (!done) void'(sb_q.pop_front());
    check("stalls", 32'(stalls), 32'(exp_stall));
    if (is_store) check("wr_count", 32'(wr_k), 32'(n));
    aluop_i = EX_NOP; wreg_i = 1'b0; is_ld_i = 1'b0; mem_gnt_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; bd_we = 1'b0; bd_a = '0; bd_d = '0;
    wd_i = 5'd5; wreg_i = 1'b1; wdata_i = 32'h1234; mem_addr_i = '0;
    is_ld_i = 1'b0; aluop_i = EX_NOP; mem_gnt_i = 1'b0;

    // Reset holds every output low even with live inputs.
    @(negedge clk);
    check("rst_wd", 32'(wd_o), 32'd0);
    check("rst_wreg", 32'(wreg_o), 32'd0);
    check("rst_wdata", wdata_o, 32'd0);
    check("rst_stall", 32'(stall_req_o), 32'd0);
    @(posedge clk); #1;

    preload(17'h00100, 8'h78); preload(17'h00101, 8'h56);
    preload(17'h00102, 8'h34); preload(17'h00103, 8'h12);
    preload(17'h00200, 8'h80);
    preload(17'h00210, 8'h34); preload(17'h00211, 8'h92);
    preload(17'h00302, 8'h11);
    preload(17'h1FFFF, 8'hA1); preload(17'h00000, 8'hB2);
    preload(17'h00001, 8'hC3); preload(17'h00002, 8'hD4);
    preload(17'h00602, 8'h77);
    rst = 1'b0;

    run_op(EX_NOP, 1'b0, 32'h0, 32'h0000_1234, 5'd5, 1'b1, 0, 1'b1, 32'h0000_1234, 0);
    run_op(EX_LW,  1'b1, 32'h100, 32'h0, 5'd6, 1'b1, 0, 1'b1, 32'h1234_5678, 4);
    run_op(EX_LB,  1'b1, 32'h200, 32'h0, 5'd7, 1'b1, 0, 1'b1, 32'hFFFF_FF80, 1);
    run_op(EX_LBU, 1'b1, 32'h200, 32'h0, 5'd8, 1'b1, 0, 1'b1, 32'h0000_0080, 1);
    run_op(EX_LH,  1'b1, 32'h210, 32'h0, 5'd9, 1'b1, 0, 1'b1, 32'hFFFF_9234, 2);
    run_op(EX_LHU, 1'b1, 32'h210, 32'h0, 5'd10, 1'b1, 0, 1'b1, 32'h0000_9234, 2);
    run_op(EX_SH,  1'b0, 32'h300, 32'hAAAA_BEEF, 5'd11, 1'b1, 0, 1'b0, 32'h0, 1);
    check("ram_300", 32'(ram[17'h300]), 32'hEF);
    check("ram_301", 32'(ram[17'h301]), 32'hBE);
    check("ram_302", 32'(ram[17'h302]), 32'h11);
    run_op(EX_SB,  1'b0, 32'h400, 32'h1234_565A, 5'd12, 1'b1, 0, 1'b0, 32'h0, 0);
    check("ram_400", 32'(ram[17'h400]), 32'h5A);
    run_op(EX_SW,  1'b0, 32'h500, 32'h89AB_CDEF, 5'd13, 1'b1, 0, 1'b0, 32'h0, 3);
    run_op(EX_LW,  1'b1, 32'h500, 32'h0, 5'd14, 1'b1, 0, 1'b1, 32'h89AB_CDEF, 4);
    // Grant withheld for three cycles, then a four-byte load.
    run_op(EX_LW,  1'b1, 32'h100, 32'h0, 5'd15, 1'b1, 3, 1'b1, 32'h1234_5678, 7);
    // Address wraps at the top of the RAM; upper address bits are ignored.
    run_op(EX_LW,  1'b1, 32'hFFFF_FFFF, 32'h0, 5'd16, 1'b1, 0, 1'b1, 32'hD4C3_B2A1, 4);
    run_op(8'h55,  1'b1, 32'h0, 32'h0000_DEAD, 5'd17, 1'b1, 0, 1'b0, 32'h0000_DEAD, 0);

    // Reset in cycle 2 of a word store.
    aluop_i = EX_SW; is_ld_i = 1'b0; mem_addr_i = 32'h600; wdata_i = 32'hCAFE_F00D;
    wd_i = 5'd18; wreg_i = 1'b0; mem_gnt_i = 1'b1;
    @(negedge clk);
    check("sw_c0_wr", 32'(mem_wr_o), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_wr", 32'(mem_wr_o), 32'd0);
    check("rstmid_stall", 32'(stall_req_o), 32'd0);
    check("rstmid_req", 32'(mem_req_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; aluop_i = EX_NOP; mem_gnt_i = 1'b0;
    wdata_i = 32'h55; wd_i = 5'd7; wreg_i = 1'b1;
    @(negedge clk);
    check("post_add_wdata", wdata_o, 32'h55);
    check("post_add_wreg", 32'(wreg_o), 32'd1);
    check("post_add_stall", 32'(stall_req_o), 32'd0);
    check("post_add_wr", 32'(mem_wr_o), 32'd0);
    @(posedge clk); #1;
    wreg_i = 1'b0;
    check("ram_600", 32'(ram[17'h600]), 32'h0D);
    check("ram_601", 32'(ram[17'h601]), 32'hF0);
    check("ram_602", 32'(ram[17'h602]), 32'h77);
    run_op(EX_LBU, 1'b1, 32'h601, 32'h0, 5'd19, 1'b1, 0, 1'b1, 32'h0000_00F0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
